alu_issue_stage: RTL and testbench

- Decode-to-execute issue stage that drives the ALU operand/control interface (inp1, inp2, alu_control) from decoded RV32I fields.
- Translates opcode/funct3/funct7 into the 4-bit ALU control encoding and selects operand B (rs2 value or immediate).
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so backpressure from execute never drops an instruction.

---
 rtl/alu_issue_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage between RV32I decode and the ALU: maps opcode/funct fields to the
// 4-bit ALU control code and holds the result in an output register backed by a skid register.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [RD_W-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [RD_W-1:0] rd_out,
  output logic            illegal
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_MUL = 4'b0110,
    ALU_XOR = 4'b0111,
    ALU_SLT = 4'b1000,
    ALU_ILL = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [RD_W-1:0] rd;
    logic            ill;
  } entry_t;

  entry_t  dec;
  entry_t  or_q;
  entry_t  sk_q;
  logic    sk_valid;
  alu_op_e op;
  logic    ok;
  logic    accept;
  logic    or_free;

  always_comb begin
    op    = ALU_ILL;
    ok    = 1'b0;
    dec.a = rs1_val;
    dec.b = rs2_val;
    dec.rd = rd_in;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          ok = 1'b1;
          case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: ok = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          ok = 1'b1;
          op = ALU_SUB;
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          ok = 1'b1;
          op = ALU_MUL;
        end
      end
      OPC_OP_IMM: begin
        dec.b = imm;
        ok    = 1'b1;
        case (funct3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_SLT;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          // Shift immediates carry only a 5-bit shift amount.
          3'b001: begin
            dec.b = {{(XLEN-5){1'b0}}, imm[4:0]};
            op    = ALU_SLL;
            ok    = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec.b = {{(XLEN-5){1'b0}}, imm[4:0]};
            op    = ALU_SRL;
            ok    = (funct7 == 7'b0000000);
          end
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec.b = imm;
        op    = ALU_ADD;
        ok    = 1'b1;
      end
      OPC_BRANCH: begin
        op = ALU_SUB;
        ok = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    dec.ill  = !ok;
    dec.ctrl = ok ? op : ALU_ILL;
  end

  assign accept  = in_valid && in_ready;
  assign or_free = !out_valid || out_ready;

  // The skid register only fills while the output register is stalled, so
  // in_ready is simply the registered complement of sk_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
      in_ready  <= 1'b1;
      or_q      <= '0;
      sk_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
      in_ready  <= 1'b1;
    end else if (or_free) begin
      if (sk_valid) begin
        or_q      <= sk_q;
        out_valid <= 1'b1;
        sk_valid  <= 1'b0;
        in_ready  <= 1'b1;
      end else if (accept) begin
        or_q      <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      sk_q     <= dec;
      sk_valid <= 1'b1;
      in_ready <= 1'b0;
    end
  end

  assign alu_a       = or_q.a;
  assign alu_b       = or_q.b;
  assign alu_control = or_q.ctrl;
  assign rd_out      = or_q.rd;
  assign illegal     = or_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference decoder pushes expected
// entries on accept, and each transfer pops and compares them.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] imm = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  rd_out;
  logic        illegal;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .rd_out(rd_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                 input logic [4:0] rd);
    exp_t e;
    e.a = a;
    e.b = b;
    e.rd = rd;
    e.ctrl = 4'hF;
    if (op == 7'h33) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: e.ctrl = 4'h2;
          3'd1: e.ctrl = 4'h3;
          3'd2: e.ctrl = 4'h8;
          3'd4: e.ctrl = 4'h7;
          3'd5: e.ctrl = 4'h5;
          3'd6: e.ctrl = 4'h1;
          3'd7: e.ctrl = 4'h0;
          default: e.ctrl = 4'hF;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 4'h4;
      else if (f7 == 7'h01 && f3 == 3'd0) e.ctrl = 4'h6;
    end else if (op == 7'h13) begin
      e.b = im;
      case (f3)
        3'd0: e.ctrl = 4'h2;
        3'd2: e.ctrl = 4'h8;
        3'd4: e.ctrl = 4'h7;
        3'd6: e.ctrl = 4'h1;
        3'd7: e.ctrl = 4'h0;
        3'd1, 3'd5: begin
          e.b = im & 32'h1F;
          if (f7 == 7'h00) e.ctrl = (f3 == 3'd1) ? 4'h3 : 4'h5;
        end
        default: e.ctrl = 4'hF;
      endcase
    end else if (op == 7'h03 || op == 7'h23) begin
      e.b = im;
      e.ctrl = 4'h2;
    end else if (op == 7'h63) begin
      e.ctrl = 4'h4;
    end
    e.ill = (e.ctrl == 4'hF);
    return e;
  endfunction

  // Queue depth mirrors DUT occupancy: any entry means out_valid, two means skid full.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    end else begin
      checkOutput("occ_out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() > 0});
      checkOutput("occ_in_ready", {63'd0, in_ready}, {63'd0, sb_q.size() < 2});
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_issue", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("alu_a", {32'd0, alu_a}, {32'd0, e.a});
            checkOutput("alu_b", {32'd0, alu_b}, {32'd0, e.b});
            checkOutput("alu_control", {60'd0, alu_control}, {60'd0, e.ctrl});
            checkOutput("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
            checkOutput("illegal", {63'd0, illegal}, {63'd0, e.ill});
          end
        end
        if (in_valid && in_ready)
          sb_q.push_back(model(opcode, funct3, funct7, rs1_val, rs2_val, imm, rd_in));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setInputs(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                           input logic [4:0] rd);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_val = a; rs2_val = b; imm = im; rd_in = rd;
    in_valid = 1'b1;
  endtask

  // Holds the entry on the inputs until the DUT takes it, bounded.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                               input logic [4:0] rd);
    logic was_ready;
    setInputs(op, f3, f7, a, b, im, rd);
    for (int i = 0; i < 50; i++) begin
      was_ready = in_ready;
      step();
      if (was_ready) return;
    end
    checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic expectNow(input string tag, input logic [3:0] ctrl, input logic [31:0] b, input logic ill);
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, "_ctrl"}, {60'd0, alu_control}, {60'd0, ctrl});
    checkOutput({tag, "_b"}, {32'd0, alu_b}, {32'd0, b});
    checkOutput({tag, "_ill"}, {63'd0, illegal}, {63'd0, ill});
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] f7s [4];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h37};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h55};

    #1 rst_n = 1'b0;
    repeat (3) step();
    checkOutput("reset_alu_control", {60'd0, alu_control}, 64'd0);
    checkOutput("reset_alu_a", {32'd0, alu_a}, 64'd0);
    checkOutput("reset_illegal", {63'd0, illegal}, 64'd0);
    rst_n = 1'b1;
    step();

    out_ready = 1'b1;
    applyStimulus(7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0, 5'd7);
    in_valid = 1'b0;
    expectNow("sub", 4'h4, 32'd3, 1'b0);
    checkOutput("sub_a", {32'd0, alu_a}, 64'd10);

    applyStimulus(7'h13, 3'd1, 7'h00, 32'd5, 32'd9, 32'hFFFF_FFE5, 5'd1);
    expectNow("slli", 4'h3, 32'd5, 1'b0);
    applyStimulus(7'h13, 3'd1, 7'h20, 32'd5, 32'd9, 32'hFFFF_FFE5, 5'd1);
    in_valid = 1'b0;
    checkOutput("slli_bad_ill", {63'd0, illegal}, 64'd1);
    checkOutput("slli_bad_ctrl", {60'd0, alu_control}, 64'hF);

    applyStimulus(7'h03, 3'd2, 7'h00, 32'd100, 32'd7, 32'h10, 5'd2);
    expectNow("load", 4'h2, 32'h10, 1'b0);
    applyStimulus(7'h63, 3'd0, 7'h00, 32'd4, 32'h1234, 32'h8, 5'd3);
    expectNow("branch", 4'h4, 32'h1234, 1'b0);
    applyStimulus(7'h7F, 3'd0, 7'h00, 32'd4, 32'h99, 32'h8, 5'd4);
    in_valid = 1'b0;
    expectNow("unknown", 4'hF, 32'h99, 1'b1);

    // Full decode table, back to back at full throughput.
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 8; k++)
        applyStimulus(7'h33, 3'(k), f7s[f], $urandom, $urandom, $urandom, 5'(k + f));
    for (int k = 0; k < 8; k++)
      applyStimulus(7'h13, 3'(k), 7'h00, $urandom, $urandom, $urandom, 5'(k));
    applyStimulus(7'h13, 3'd5, 7'h20, 32'd1, 32'd2, 32'h3F, 5'd9);
    applyStimulus(7'h23, 3'd2, 7'h00, 32'd1, 32'd2, 32'hFFFF_FFFC, 5'd10);
    in_valid = 1'b0;
    step();

    out_ready = 1'b0;
    applyStimulus(7'h13, 3'd0, 7'h00, 32'd0, 32'd0, 32'd1, 5'd11);
    applyStimulus(7'h13, 3'd0, 7'h00, 32'd0, 32'd0, 32'd2, 5'd12);
    setInputs(7'h13, 3'd0, 7'h00, 32'd0, 32'd0, 32'd3, 5'd13);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("bp_hold_b", {32'd0, alu_b}, 64'd1);
      step();
    end
    out_ready = 1'b1;
    applyStimulus(7'h13, 3'd0, 7'h00, 32'd0, 32'd0, 32'd3, 5'd13);
    in_valid = 1'b0;
    repeat (3) step();

    out_ready = 1'b0;
    applyStimulus(7'h33, 3'd4, 7'h00, 32'd1, 32'd2, 32'd0, 5'd14);
    applyStimulus(7'h33, 3'd6, 7'h00, 32'd3, 32'd4, 32'd0, 5'd15);
    setInputs(7'h33, 3'd7, 7'h00, 32'd5, 32'd6, 32'd0, 5'd16);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
    setInputs(7'h33, 3'd0, 7'h01, 32'd7, 32'd8, 32'd0, 5'd17);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("flush_drop_valid", {63'd0, out_valid}, 64'd0);
    repeat (3) step();

    out_ready = 1'b0;
    applyStimulus(7'h13, 3'd4, 7'h00, 32'd9, 32'd0, 32'hF0, 5'd18);
    applyStimulus(7'h13, 3'd6, 7'h00, 32'd9, 32'd0, 32'h0F, 5'd19);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("async_alu_control", {60'd0, alu_control}, 64'd0);
    checkOutput("async_alu_a", {32'd0, alu_a}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        setInputs(ops[$urandom_range(0, 6)], 3'($urandom), f7s[$urandom_range(0, 3)],
                  $urandom, $urandom, $urandom, 5'($urandom));
      else
        in_valid = 1'b0;
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
